// File: rtl/vector_packer_pkg.sv
// rtl/vector_packer_pkg.sv - shared FSM encodings and slot index width helpers
package vector_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    // Ceiling log2; the selection mux derives its select width with the same function.
    function automatic int clogb2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Slot index width; a single-slot vector still needs a one-bit index.
    function automatic int iw_of(input int n);
        return (n > 1) ? clogb2(n) : 1;
    endfunction

endpackage

// File: rtl/vector_packer_if.sv
// rtl/vector_packer_if.sv - element input stream and packed vector output bundle
interface vector_packer_if
    import vector_packer_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 8
);
    localparam int DW_VEC = N * DW;
    localparam int IW     = iw_of(N);

    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [IW-1:0]     wr_idx;
    logic              out_valid;
    logic              out_ready;
    logic [DW_VEC-1:0] out_vec;

    // Producer of elements and consumer of the packed vector.
    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, wr_idx, out_valid, out_vec
    );

    // The packer itself.
    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, wr_idx, out_valid, out_vec
    );

endinterface

// File: rtl/vector_packer.sv
// rtl/vector_packer.sv - packs N serial elements into one held DW_VEC-bit vector
module vector_packer
    import vector_packer_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    vector_packer_if.slave bus
);
    localparam int DW_VEC = N * DW;
    localparam int IW     = iw_of(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t            state_q;
    state_t            state_d;
    logic [DW_VEC-1:0] vec_q;
    logic [IW-1:0]     idx_q;
    logic              out_valid_q;
    logic              in_ready_c;
    logic              clear_c;
    logic              beat_c;

    // A start that the FSM honours: always in IDLE/FILL, in FULL only when the vector is taken.
    assign clear_c = bus.start &&
                     ((state_q == ST_IDLE) || (state_q == ST_FILL) ||
                      ((state_q == ST_FULL) && bus.out_ready));
    assign beat_c  = bus.in_valid && in_ready_c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; the vector is never released without out_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (bus.start)                         state_d = ST_FILL;
                else if (bus.in_valid && idx_q == LAST_IDX) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (bus.out_ready) state_d = bus.start ? ST_FILL : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode; a restarting cycle refuses the beat so it cannot land in a cleared vector.
    always_comb begin
        in_ready_c = (state_q == ST_FILL) && !bus.start;
    end

    // Vector storage and slot index; unwritten slots keep the zero left by the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= '0;
            idx_q <= '0;
        end else if (clear_c) begin
            vec_q <= '0;
            idx_q <= '0;
        end else if (beat_c) begin
            vec_q[int'(idx_q)*DW +: DW] <= bus.in_data;
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    // Registered completion flag, high exactly while the FSM holds a full vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_d == ST_FULL);
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.wr_idx    = idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_vec   = vec_q;

endmodule

// File: tb/tb_vector_packer.sv
// tb/tb_vector_packer.sv - self-checking bench for vector_packer (N=4/DW=8 and N=1/DW=16)
module tb_vector_packer;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    vector_packer_if #(.N(4), .DW(8))  if4 ();
    vector_packer_if #(.N(1), .DW(16)) if1 ();

    vector_packer #(.N(4), .DW(8)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    vector_packer #(.N(1), .DW(16)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        iv;
        logic [7:0]  d;
        logic        ordy;
        logic        e_rdy;
        logic [1:0]  e_idx;
        logic        e_ov;
        logic [31:0] e_vec;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: collected elements and whether a full vector is held.
    logic [7:0]  mq[$];
    bit          m_collecting;
    bit          m_holding;
    logic [31:0] m_vec;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic iv, input logic [7:0] d, input logic ordy);
        if4.start     = st;
        if4.in_valid  = iv;
        if4.in_data   = d;
        if4.out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic st, input logic iv, input logic [7:0] d, input logic ordy);
        if (m_holding) begin
            if (ordy) begin
                m_holding = 0;
                if (st) begin
                    m_collecting = 1;
                    mq.delete();
                    m_vec = 0;
                end
            end
        end else if (m_collecting) begin
            if (st) begin
                mq.delete();
                m_vec = 0;
            end else if (iv) begin
                mq.push_back(d);
                m_vec = m_vec | (32'(d) << (8 * (mq.size() - 1)));
                if (mq.size() == 4) begin
                    m_collecting = 0;
                    m_holding    = 1;
                    mq.delete();
                end
            end
        end else if (st) begin
            m_collecting = 1;
            mq.delete();
            m_vec = 0;
        end
    endtask

    initial begin
        logic        st, iv, ordy;
        logic [7:0]  d;
        logic [31:0] held;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive(0, 0, 8'h00, 0);
        if1.start = 0; if1.in_valid = 0; if1.in_data = 16'h0; if1.out_ready = 0;

        #12;
        check("reset_out_vec",   64'(if4.out_vec),   64'h0);
        check("reset_wr_idx",    64'(if4.wr_idx),    64'h0);
        check("reset_out_valid", 64'(if4.out_valid), 64'h0);
        check("reset_in_ready",  64'(if4.in_ready),  64'h0);
        rst_n = 1'b1;
        tick();

        // start, fill, hold, drain, idle-ignore, restart mid-fill, FULL restart
        tbl.push_back('{1, 0, 8'h00, 0, 0, 2'd0, 0, 32'h0000_0000});
        tbl.push_back('{0, 1, 8'h11, 0, 1, 2'd1, 0, 32'h0000_0011});
        tbl.push_back('{0, 1, 8'h22, 0, 1, 2'd2, 0, 32'h0000_2211});
        tbl.push_back('{0, 1, 8'h33, 0, 1, 2'd3, 0, 32'h0033_2211});
        tbl.push_back('{0, 1, 8'h44, 0, 1, 2'd0, 1, 32'h4433_2211});
        tbl.push_back('{0, 1, 8'h55, 0, 0, 2'd0, 1, 32'h4433_2211});
        tbl.push_back('{1, 0, 8'h00, 0, 0, 2'd0, 1, 32'h4433_2211});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 2'd0, 0, 32'h4433_2211});
        tbl.push_back('{0, 1, 8'h66, 0, 0, 2'd0, 0, 32'h4433_2211});
        tbl.push_back('{1, 1, 8'h77, 0, 0, 2'd0, 0, 32'h0000_0000});
        tbl.push_back('{0, 1, 8'hAA, 0, 1, 2'd1, 0, 32'h0000_00AA});
        tbl.push_back('{0, 1, 8'hBB, 0, 1, 2'd2, 0, 32'h0000_BBAA});
        tbl.push_back('{1, 1, 8'hCC, 0, 0, 2'd0, 0, 32'h0000_0000});
        tbl.push_back('{0, 1, 8'h01, 0, 1, 2'd1, 0, 32'h0000_0001});
        tbl.push_back('{0, 1, 8'h02, 0, 1, 2'd2, 0, 32'h0000_0201});
        tbl.push_back('{0, 1, 8'h03, 0, 1, 2'd3, 0, 32'h0003_0201});
        tbl.push_back('{0, 1, 8'h04, 0, 1, 2'd0, 1, 32'h0403_0201});
        tbl.push_back('{1, 0, 8'h00, 1, 0, 2'd0, 0, 32'h0000_0000});
        tbl.push_back('{0, 1, 8'h12, 0, 1, 2'd1, 0, 32'h0000_0012});
        tbl.push_back('{1, 0, 8'h00, 0, 0, 2'd0, 0, 32'h0000_0000});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            #1;
            check($sformatf("tbl%0d_in_ready", i), 64'(if4.in_ready), 64'(tbl[i].e_rdy));
            tick();
            check($sformatf("tbl%0d_wr_idx", i),    64'(if4.wr_idx),    64'(tbl[i].e_idx));
            check($sformatf("tbl%0d_out_valid", i), 64'(if4.out_valid), 64'(tbl[i].e_ov));
            check($sformatf("tbl%0d_out_vec", i),   64'(if4.out_vec),   64'(tbl[i].e_vec));
        end

        // Beats every third cycle, then hold off the consumer for 10 cycles.
        for (int k = 0; k < 4; k++) begin
            check("gap_wr_idx", 64'(if4.wr_idx), 64'(k));
            drive(0, 1, 8'(8'h21 * (k + 1)), 0);
            tick();
            drive(0, 0, 8'h00, 0);
            tick();
            if (k < 3) tick();
        end
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 8'($urandom), 0);
            #1;
            check("hold_in_ready", 64'(if4.in_ready), 64'h0);
            tick();
            check("hold_out_valid", 64'(if4.out_valid), 64'h1);
            check("hold_out_vec",   64'(if4.out_vec),   64'h8463_4221);
        end
        drive(0, 0, 8'h00, 1);
        tick();
        check("drain_out_valid", 64'(if4.out_valid), 64'h0);

        // Asynchronous reset mid-fill, away from any clock edge.
        drive(1, 0, 8'h00, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 8'(8'hA1 + k), 0);
            tick();
        end
        drive(0, 0, 8'h00, 0);
        check("prerst_out_vec", 64'(if4.out_vec), 64'h00A3_A2A1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_vec",   64'(if4.out_vec),   64'h0);
        check("arst_wr_idx",    64'(if4.wr_idx),    64'h0);
        check("arst_out_valid", 64'(if4.out_valid), 64'h0);
        check("arst_in_ready",  64'(if4.in_ready),  64'h0);
        #2 rst_n = 1'b1;
        tick();

        // Randomized traffic against the reference model.
        m_collecting = 0;
        m_holding    = 0;
        m_vec        = 0;
        mq.delete();
        for (int c = 0; c < 400; c++) begin
            st   = ($urandom_range(0, 9) == 0);
            iv   = ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 2) == 0);
            d    = 8'($urandom);
            drive(st, iv, d, ordy);
            #1;
            check("rnd_in_ready", 64'(if4.in_ready), 64'(m_collecting && !st));
            model_step(st, iv, d, ordy);
            tick();
            check("rnd_wr_idx",    64'(if4.wr_idx),    64'(m_collecting ? mq.size() : 0));
            check("rnd_out_valid", 64'(if4.out_valid), 64'(m_holding));
            check("rnd_out_vec",   64'(if4.out_vec),   64'(m_vec));
        end
        drive(0, 0, 8'h00, 0);

        // Single-slot packer.
        if1.start = 1;
        tick();
        if1.start    = 0;
        if1.in_valid = 1;
        if1.in_data  = 16'hBEEF;
        #1;
        check("n1_in_ready", 64'(if1.in_ready), 64'h1);
        tick();
        if1.in_valid = 0;
        held = 32'(if1.out_vec);
        check("n1_out_vec",   64'(held),          64'hBEEF);
        check("n1_out_valid", 64'(if1.out_valid), 64'h1);
        check("n1_wr_idx",    64'(if1.wr_idx),    64'h0);
        if1.out_ready = 1;
        tick();
        if1.out_ready = 0;
        check("n1_drain", 64'(if1.out_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
